rsa_pio_mailbox: RTL and testbench
==================================

// Module: rsa_pio_mailbox
// PURPOSE
//  Parametrised SW<->HW mailbox between the Nios PIO pairs (to_hw_port/to_hw_sig, to_sw_port/to_sw_sig)
//  and the RSA datapath. Assembles NUM_OPS wide operands from WORD_W-bit PIO writes using a 4-phase
//  command/ack handshake, launches the core with a valid/ready handshake, and returns the result to SW
//  word by word. Generalises the fixed 32-bit/4-bit PIO link to any operand width and operand count.
// PARAMETERS
//  WORD_W   32   PIO data width
//  SIG_W    4    PIO signal width (>=4)
//  OP_WIDTH 512  operand/result width in bits; must be a multiple of WORD_W
//  NUM_OPS  3    operand slots (0=message, 1=exponent, 2=modulus)
// PORTS
//  clk_clk      in   1                 single clock
//  reset_reset  in   1                 asynchronous, active-high reset
//  to_hw_port   in   WORD_W            SW data word / SEL index
//  to_hw_sig    in   SIG_W             SW command code
//  to_sw_port   out  WORD_W            result word to SW
//  to_sw_sig    out  SIG_W             {BUSY,ERR,RES_AVAIL,ACK} = bits [3:0]; upper bits 0
//  op_data      out  NUM_OPS*OP_WIDTH  operand slot k at [k*OP_WIDTH +: OP_WIDTH]
//  op_valid     out  1                 operands valid to core
//  op_ready     in   1                 core accepts operands
//  res_data     in   OP_WIDTH          core result
//  res_valid    in   1                 result valid
//  res_ready    out  1                 mailbox accepts result
// BEHAVIOUR
//  Reset: all outputs 0, operand slots 0, sel=0, wptr=0, rptr=0, state IDLE.
//  Commands: 0 IDLE, 1 WRITE, 2 SEL, 3 START, 4 READ, 5 CLEAR; 6..max are illegal -> ERR, no action.
//  Handshake: in IDLE, a non-zero cmd executes in the cycle it is sampled; ACK=1 on the next cycle, held
//   in state ACK until cmd==0, then ACK=0 next cycle. A cmd is never executed twice per handshake.
//  WRITE: slot[sel][wptr*WORD_W +: WORD_W] <= to_hw_port; wptr++. At wptr==OP_WIDTH/WORD_W-1: wptr->0,
//   sel->(sel+1) mod NUM_OPS.
//  SEL: if to_hw_port<NUM_OPS then sel<=to_hw_port, wptr<=0; else set ERR, sel/wptr unchanged.
//  START: if BUSY=1, set ERR and ignore. Otherwise BUSY=1, op_valid=1 (held until op_ready),
//   RES_AVAIL=0. The ACK phase runs concurrently; op_valid is not gated by ACK.
//  Core phase: op_valid&op_ready -> op_valid=0. res_ready=1 while BUSY and op_valid=0. On
//   res_valid&res_ready: capture res_data, rptr=0, RES_AVAIL=1, BUSY=0. Same-cycle op_ready&res_valid is legal.
//  READ: if RES_AVAIL, to_sw_port<=res word rptr (LSW first), rptr++. After the last word RES_AVAIL=0.
//   If RES_AVAIL=0: to_sw_port<=0, ERR=1.
//   to_sw_port is stable from ACK rise until the next READ.
//  CLEAR: sel, wptr and rptr reset to 0; ERR and RES_AVAIL cleared. Slots keep their contents.
//   A running computation is not aborted.
//  ERR is sticky and clears only on CLEAR or reset. Operand writes while BUSY are legal; they modify
//   slots the core may still be reading, so SW must avoid them.
//  Async reset mid-operation: everything returns to reset values immediately; SW must re-handshake.
// CONFIGURATION
//  RSA_PIO_SYNC_EN defined: to_hw_sig and to_hw_port pass through 2-flop synchronisers before decode
//   (for a PIO clocked from a different domain). The command must be seen stable for 2 consecutive
//   synced samples before execution. ACK latency is +3 cycles.
//  RSA_PIO_SYNC_EN undefined: inputs are used directly; ACK appears 1 cycle after the cmd is sampled.
// STRUCTURE
//  rsa_pio_pkg: cmd_t enum (CMD_IDLE..CMD_CLEAR), state_t {S_IDLE,S_ACK}, SIG_* bit-position localparams,
//   function words_per_op(OP_WIDTH,WORD_W).
//  Sub-module pio_sync_2ff (WIDTH param) is instantiated only under RSA_PIO_SYNC_EN.
//  Elaboration check: OP_WIDTH % WORD_W == 0 and SIG_W >= 4; fail at elaboration otherwise.
// TESTING
//  1. Reset -> to_sw_sig=0, op_valid=0, res_ready=0, op_data=0.
//  2. SEL 2; WRITE 0x1..0x10 (16 words) -> slot2 = {0x10,...,0x1}, sel wraps to 0. Each ACK rises 1 cycle
//     after the cmd and falls 1 cycle after IDLE.
//  3. START with op_ready held 0 for 5 cycles -> op_valid=1 and BUSY=1 throughout. A second START sets
//     ERR=1, with no new launch.
//  4. Core returns res_data = 512'h...0200000001 -> RES_AVAIL=1. READ x16 returns 0x1, 0x2, ... and
//     RES_AVAIL=0 after the 16th. A 17th READ returns 0 and sets ERR=1.
//  5. SEL 3 (>=NUM_OPS) -> ERR=1, sel unchanged. Cmd 7 -> ERR. CLEAR -> ERR=0, wptr=0.
//  6. reset_reset pulsed mid-WRITE and again while BUSY -> all outputs 0 in the same cycle. A fresh SEL/WRITE
//     sequence then works. Rerun tests 2-4 with RSA_PIO_SYNC_EN defined: ACK latency is 4 cycles.

Source files
------------

// File: rtl/rsa_pio_pkg.sv
// Shared types and constants for the RSA PIO mailbox: command codes, handshake states,
// status-bit positions and the operand word-count helper.
package rsa_pio_pkg;

  typedef enum logic [2:0] {
    CMD_IDLE  = 3'd0,
    CMD_WRITE = 3'd1,
    CMD_SEL   = 3'd2,
    CMD_START = 3'd3,
    CMD_READ  = 3'd4,
    CMD_CLEAR = 3'd5
  } cmd_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } state_t;

  localparam int unsigned SIG_ACK       = 0;
  localparam int unsigned SIG_RES_AVAIL = 1;
  localparam int unsigned SIG_ERR       = 2;
  localparam int unsigned SIG_BUSY      = 3;

  // Codes at or above this value are illegal.
  localparam int unsigned NUM_CMDS = 6;

  function automatic int unsigned words_per_op(int unsigned op_width, int unsigned word_w);
    return op_width / word_w;
  endfunction

endpackage

// File: rtl/pio_sync_2ff.sv
// Two-flop synchroniser for a bus crossing in from the PIO clock domain.
module pio_sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/rsa_pio_mailbox.sv
// SW<->HW mailbox between Nios PIO pairs and the RSA core: operand assembly, launch, result readback.
// Define RSA_PIO_SYNC_EN to synchronise the PIO inputs from a foreign clock domain.
module rsa_pio_mailbox
  import rsa_pio_pkg::*;
#(
  parameter int unsigned WORD_W   = 32,
  parameter int unsigned SIG_W    = 4,
  parameter int unsigned OP_WIDTH = 512,
  parameter int unsigned NUM_OPS  = 3
) (
  input  logic                        clk_clk,
  input  logic                        reset_reset,
  input  logic [WORD_W-1:0]           to_hw_port,
  input  logic [SIG_W-1:0]            to_hw_sig,
  output logic [WORD_W-1:0]           to_sw_port,
  output logic [SIG_W-1:0]            to_sw_sig,
  output logic [NUM_OPS*OP_WIDTH-1:0] op_data,
  output logic                        op_valid,
  input  logic                        op_ready,
  input  logic [OP_WIDTH-1:0]         res_data,
  input  logic                        res_valid,
  output logic                        res_ready
);

  localparam int unsigned Wpo  = words_per_op(OP_WIDTH, WORD_W);
  localparam int unsigned SelW = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
  localparam int unsigned PtrW = (Wpo > 1) ? $clog2(Wpo) : 1;

  if ((OP_WIDTH % WORD_W) != 0 || SIG_W < 4) begin : g_bad_params
    $error("rsa_pio_mailbox: OP_WIDTH must be a multiple of WORD_W and SIG_W must be >= 4");
  end

  logic [SIG_W-1:0]  sig_in;
  logic [WORD_W-1:0] port_in;
  logic              cmd_ok;

`ifdef RSA_PIO_SYNC_EN
  logic [SIG_W+WORD_W-1:0] sync_out;
  logic [SIG_W-1:0]        sig_prev_q;

  pio_sync_2ff #(
    .WIDTH(SIG_W + WORD_W)
  ) u_sync (
    .clk_i(clk_clk),
    .rst_i(reset_reset),
    .d_i  ({to_hw_sig, to_hw_port}),
    .q_o  (sync_out)
  );

  assign {sig_in, port_in} = sync_out;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) sig_prev_q <= '0;
    else             sig_prev_q <= sig_in;
  end

  // Act only once two consecutive synced samples agree.
  assign cmd_ok = (sig_in == sig_prev_q);
`else
  assign sig_in  = to_hw_sig;
  assign port_in = to_hw_port;
  assign cmd_ok  = 1'b1;
`endif

  state_t                           state_q, state_d;
  logic [NUM_OPS-1:0][OP_WIDTH-1:0] slots_q, slots_d;
  logic [OP_WIDTH-1:0]              res_q, res_d;
  logic [SelW-1:0]                  sel_q, sel_d;
  logic [PtrW-1:0]                  wptr_q, wptr_d;
  logic [PtrW-1:0]                  rptr_q, rptr_d;
  logic [WORD_W-1:0]                out_q, out_d;
  logic                             busy_q, busy_d;
  logic                             err_q, err_d;
  logic                             avail_q, avail_d;
  logic                             opv_q, opv_d;
  logic                             legal;
  logic                             res_rdy;
  cmd_t                             cmd;

  assign res_rdy = busy_q & ~opv_q;
  assign legal   = (sig_in < SIG_W'(NUM_CMDS));
  assign cmd     = cmd_t'(sig_in[2:0]);

  always_comb begin
    state_d = state_q;
    slots_d = slots_q;
    res_d   = res_q;
    sel_d   = sel_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    out_d   = out_q;
    busy_d  = busy_q;
    err_d   = err_q;
    avail_d = avail_q;
    opv_d   = opv_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_ok && (sig_in != '0)) begin
          state_d = S_ACK;
          if (!legal) begin
            err_d = 1'b1;
          end else begin
            case (cmd)
              CMD_WRITE: begin
                slots_d[sel_q][int'(wptr_q)*WORD_W +: WORD_W] = port_in;
                if (wptr_q == PtrW'(Wpo - 1)) begin
                  wptr_d = '0;
                  sel_d  = (sel_q == SelW'(NUM_OPS - 1)) ? '0 : sel_q + SelW'(1);
                end else begin
                  wptr_d = wptr_q + PtrW'(1);
                end
              end
              CMD_SEL: begin
                if (port_in < WORD_W'(NUM_OPS)) begin
                  sel_d  = port_in[SelW-1:0];
                  wptr_d = '0;
                end else begin
                  err_d = 1'b1;
                end
              end
              CMD_START: begin
                if (busy_q) begin
                  err_d = 1'b1;
                end else begin
                  busy_d  = 1'b1;
                  opv_d   = 1'b1;
                  avail_d = 1'b0;
                end
              end
              CMD_READ: begin
                if (avail_q) begin
                  out_d = res_q[int'(rptr_q)*WORD_W +: WORD_W];
                  if (rptr_q == PtrW'(Wpo - 1)) begin
                    rptr_d  = '0;
                    avail_d = 1'b0;
                  end else begin
                    rptr_d = rptr_q + PtrW'(1);
                  end
                end else begin
                  out_d = '0;
                  err_d = 1'b1;
                end
              end
              CMD_CLEAR: begin
                sel_d   = '0;
                wptr_d  = '0;
                rptr_d  = '0;
                err_d   = 1'b0;
                avail_d = 1'b0;
              end
              default: ;
            endcase
          end
        end
      end
      S_ACK: begin
        if (cmd_ok && (sig_in == '0)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Core handshakes run independently of the SW handshake.
    if (opv_q && op_ready) opv_d = 1'b0;
    if (res_valid && res_rdy) begin
      res_d   = res_data;
      rptr_d  = '0;
      avail_d = 1'b1;
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q <= S_IDLE;
      slots_q <= '0;
      res_q   <= '0;
      sel_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      avail_q <= 1'b0;
      opv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slots_q <= slots_d;
      res_q   <= res_d;
      sel_q   <= sel_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      avail_q <= avail_d;
      opv_q   <= opv_d;
    end
  end

  always_comb begin
    to_sw_sig                = '0;
    to_sw_sig[SIG_ACK]       = (state_q == S_ACK);
    to_sw_sig[SIG_RES_AVAIL] = avail_q;
    to_sw_sig[SIG_ERR]       = err_q;
    to_sw_sig[SIG_BUSY]      = busy_q;
  end

  assign to_sw_port = out_q;
  assign op_data    = slots_q;
  assign op_valid   = opv_q;
  assign res_ready  = res_rdy;

endmodule

// File: tb/tb_rsa_pio_mailbox.sv
// Directed, table-driven bench for rsa_pio_mailbox with default parameters.
module tb_rsa_pio_mailbox;

`ifdef RSA_PIO_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  to_hw_port = '0;
  logic [3:0]   to_hw_sig = '0;
  logic [31:0]  to_sw_port;
  logic [3:0]   to_sw_sig;
  logic [1535:0] op_data;
  logic         op_valid;
  logic         op_ready = 1'b0;
  logic [511:0] res_data = '0;
  logic         res_valid = 1'b0;
  logic         res_ready;

  int n_chk  = 0;
  int n_fail = 0;

  rsa_pio_mailbox u_dut (
    .clk_clk    (clk),
    .reset_reset(rst),
    .to_hw_port (to_hw_port),
    .to_hw_sig  (to_hw_sig),
    .to_sw_port (to_sw_port),
    .to_sw_sig  (to_sw_sig),
    .op_data    (op_data),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .res_data   (res_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] port;
    logic [3:0]  exp_sig;
    bit          chk_out;
    logic [31:0] exp_out;
    bit          chk_slot;
    int          slot;
    int          word;
    logic [31:0] exp_word;
  } vec_t;

  vec_t va[$];
  vec_t vb[$];

  function automatic vec_t mk(logic [3:0] c, logic [31:0] p, logic [3:0] es, bit co,
                              logic [31:0] eo, bit cs, int s, int w, logic [31:0] ew);
    vec_t v;
    v.cmd = c; v.port = p; v.exp_sig = es; v.chk_out = co; v.exp_out = eo;
    v.chk_slot = cs; v.slot = s; v.word = w; v.exp_word = ew;
    return v;
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic hs(input logic [3:0] c, input logic [31:0] d);
    int n;
    @(posedge clk); #1;
    to_hw_port = d;
    to_hw_sig  = c;
    n = 0;
    while (!to_sw_sig[0] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("ack_rise_latency", n, LAT);
    to_hw_sig = '0;
    n = 0;
    while (to_sw_sig[0] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("ack_fall_latency", n, LAT);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    hs(v.cmd, v.port);
    check($sformatf("sig[%0d]", idx), 512'(to_sw_sig), 512'(v.exp_sig));
    if (v.chk_out) check($sformatf("sw_port[%0d]", idx), 512'(to_sw_port), 512'(v.exp_out));
    if (v.chk_slot)
      check($sformatf("slot%0d_w%0d[%0d]", v.slot, v.word, idx),
            512'(op_data[v.slot*512 + v.word*32 +: 32]), 512'(v.exp_word));
  endtask

  logic [511:0] exp_res;
  int           n;

  initial begin
    // Vector tables.
    va.push_back(mk(4'd2, 32'd2, 4'h0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 16; k++)
      va.push_back(mk(4'd1, 32'(k + 1), 4'h0, 0, 0, 1, 2, k, 32'(k + 1)));
    va.push_back(mk(4'd1, 32'hAA, 4'h0, 0, 0, 1, 0, 0, 32'hAA));

    for (int k = 0; k < 16; k++)
      vb.push_back(mk(4'd4, 0, (k < 15) ? 4'h2 : 4'h0, 1, 32'(k + 1), 0, 0, 0, 0));
    vb.push_back(mk(4'd4, 0, 4'h4, 1, 32'h0, 0, 0, 0, 0));
    vb.push_back(mk(4'd5, 0, 4'h0, 0, 0, 0, 0, 0, 0));
    vb.push_back(mk(4'd2, 32'd1, 4'h0, 0, 0, 0, 0, 0, 0));
    vb.push_back(mk(4'd2, 32'd3, 4'h4, 0, 0, 0, 0, 0, 0));
    vb.push_back(mk(4'd1, 32'h55, 4'h4, 0, 0, 1, 1, 0, 32'h55));
    vb.push_back(mk(4'd7, 0, 4'h4, 0, 0, 0, 0, 0, 0));
    vb.push_back(mk(4'd5, 0, 4'h0, 0, 0, 0, 0, 0, 0));
    vb.push_back(mk(4'd6, 0, 4'h4, 0, 0, 0, 0, 0, 0));
    vb.push_back(mk(4'd5, 0, 4'h0, 0, 0, 0, 0, 0, 0));
    vb.push_back(mk(4'd2, 32'd1, 4'h0, 0, 0, 0, 0, 0, 0));
    vb.push_back(mk(4'd1, 32'h66, 4'h0, 0, 0, 1, 1, 0, 32'h66));
    vb.push_back(mk(4'd1, 32'h77, 4'h0, 0, 0, 1, 1, 1, 32'h77));
    vb.push_back(mk(4'd5, 0, 4'h0, 0, 0, 0, 0, 0, 0));
    vb.push_back(mk(4'd1, 32'h88, 4'h0, 0, 0, 1, 0, 0, 32'h88));

    for (int k = 0; k < 16; k++) exp_res[k*32 +: 32] = 32'(k + 1);

    // Reset state.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_sig", 512'(to_sw_sig), 512'h0);
    check("rst_op_valid", 512'(op_valid), 512'h0);
    check("rst_res_ready", 512'(res_ready), 512'h0);
    check("rst_op_data", 512'(op_data == '0), 512'h1);

    // Operand assembly.
    foreach (va[i]) run_vec(va[i], i);
    check("slot2_full", op_data[1024 +: 512], exp_res);
    check("slot1_zero", op_data[512 +: 512], 512'h0);

    // Launch with the core stalled.
    hs(4'd3, 0);
    check("start_sig", 512'(to_sw_sig), 512'h8);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("stall_op_valid[%0d]", c), 512'(op_valid), 512'h1);
      check($sformatf("stall_busy[%0d]", c), 512'(to_sw_sig[3]), 512'h1);
      check($sformatf("stall_res_ready[%0d]", c), 512'(res_ready), 512'h0);
      @(posedge clk); #1;
    end
    hs(4'd3, 0);
    check("start2_sig", 512'(to_sw_sig), 512'hC);
    check("start2_op_valid", 512'(op_valid), 512'h1);
    hs(4'd5, 0);
    check("clear_busy_sig", 512'(to_sw_sig), 512'h8);

    @(posedge clk); #1 op_ready = 1'b1;
    @(posedge clk); #1 op_ready = 1'b0;
    check("accept_op_valid", 512'(op_valid), 512'h0);
    check("accept_res_ready", 512'(res_ready), 512'h1);
    res_data = exp_res;
    res_valid = 1'b1;
    @(posedge clk); #1 res_valid = 1'b0;
    check("result_sig", 512'(to_sw_sig), 512'h2);
    check("result_res_ready", 512'(res_ready), 512'h0);

    // Readback and error handling.
    foreach (vb[i]) run_vec(vb[i], 100 + i);

    // Async reset during a WRITE handshake.
    @(posedge clk); #1;
    to_hw_port = 32'h1234;
    to_hw_sig  = 4'd1;
    n = 0;
    while (!to_sw_sig[0] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("midwrite_ack", 512'(to_sw_sig[0]), 512'h1);
    #2 rst = 1'b1;
    #1;
    check("midwrite_rst_sig", 512'(to_sw_sig), 512'h0);
    check("midwrite_rst_op_data", 512'(op_data == '0), 512'h1);
    to_hw_sig = '0;
    @(posedge clk); #1 rst = 1'b0;

    // Async reset while the core is busy.
    hs(4'd3, 0);
    check("busy_before_rst", 512'(to_sw_sig), 512'h8);
    #2 rst = 1'b1;
    #1;
    check("busy_rst_sig", 512'(to_sw_sig), 512'h0);
    check("busy_rst_op_valid", 512'(op_valid), 512'h0);
    check("busy_rst_res_ready", 512'(res_ready), 512'h0);
    @(posedge clk); #1 rst = 1'b0;

    hs(4'd2, 32'd0);
    hs(4'd1, 32'h99);
    check("post_rst_slot0_w0", 512'(op_data[31:0]), 512'h99);
    check("post_rst_sig", 512'(to_sw_sig), 512'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
